// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style accumulator datapath: data width,
// instruction opcodes and a small zero-detect helper.
package sap_pkg;

  // Width of A, B, ALU operands and results
  localparam int DW = 4;

  // Upper instruction-register nibble as decoded by the ALU and sequencer
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_XCHG  = 4'b0011,
    OP_AND   = 4'b0100,
    OP_SHR   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_MOV_A = 4'b0111
  } opcode_e;

  // Zero-detect on a DW-wide word
  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/sap_alu4.sv
// Purely combinational ALU of the SAP datapath.
// Computes y and a carry/borrow bit from A, B and the IR opcode; no state.
// Opcodes without an arithmetic meaning pass A through with carry cleared.
module sap_alu4
  import sap_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opcode,
  output logic [W-1:0] y,
  output logic         c
);

  // One extra bit on top so that bit W carries the carry out / borrow
  logic [W:0] ext;

  // Opcode decode into an extended-width result
  always_comb begin
    ext = {1'b0, a};
    unique case (opcode)
      OP_ADD: ext = {1'b0, a} + {1'b0, b};
      OP_SUB: ext = {1'b0, a} - {1'b0, b};
      OP_AND: ext = {1'b0, a & b};
      OP_SHR: ext = {a[0], 1'b0, a[W-1:1]};
      OP_SHL: ext = {a[W-1], a[W-2:0], 1'b0};
      default: ext = {1'b0, a};
    endcase
  end

  // Split the extended result into data and flag
  always_comb begin
    y = ext[W-1:0];
    c = ext[W];
  end

endmodule

// File: rtl/sap_alu_ab_datapath.sv
// Accumulator datapath of the SAP-style CPU: A and B registers, zero/carry
// flags and the combinational ALU. Loads are steered by one-hot strobes from
// the control sequencer; every register updates on the rising clock edge.
// Optional feature: define SAP_RCL_EN to enable rotate-B-left-through-carry
// on the ercl strobe. Without it, ercl and carry_in have no effect.
module sap_alu_ab_datapath
  import sap_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] ram_din,
  input  logic [DW-1:0] tmp_din,
  input  logic [DW-1:0] pop_din,
  input  logic          carry_in,
  input  logic          la_ram,
  input  logic          la_b,
  input  logic          la_alu,
  input  logic          lb_tmp,
  input  logic          lb_alu,
  input  logic          lb_pop,
  input  logic          eu,
  input  logic          ercl,
  output logic [DW-1:0] a_q,
  output logic [DW-1:0] b_q,
  output logic [DW-1:0] alu_y,
  output logic          zero,
  output logic          carry
);

  logic [DW-1:0] a_d;
  logic [DW-1:0] b_d;
  logic          zero_q;
  logic          zero_d;
  logic          carry_q;
  logic          carry_d;
  logic          alu_c;
  logic          rcl_go;

  sap_alu4 #(.W(DW)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .opcode (opcode),
    .y      (alu_y),
    .c      (alu_c)
  );

`ifdef SAP_RCL_EN
  // Rotate only when no higher-priority B load claims the register this edge
  always_comb begin
    rcl_go = ercl & ~lb_alu & ~lb_tmp & ~lb_pop;
  end
`else
  // Rotate disabled: ercl and carry_in are intentionally left unconnected
  logic unused_rcl;
  always_comb begin
    rcl_go     = 1'b0;
    unused_rcl = ^{ercl, carry_in};
  end
`endif

  // A load mux: ALU result beats B, which beats RAM; otherwise hold
  always_comb begin
    a_d = a_q;
    if (la_alu)      a_d = alu_y;
    else if (la_b)   a_d = b_q;
    else if (la_ram) a_d = ram_din;
  end

  // B load mux: ALU, TMP, stack pop, then rotate; otherwise hold.
  // A reads the old B on the same edge, so la_b + lb_tmp swaps through TMP.
  always_comb begin
    b_d = b_q;
    if (lb_alu)      b_d = alu_y;
    else if (lb_tmp) b_d = tmp_din;
    else if (lb_pop) b_d = pop_din;
`ifdef SAP_RCL_EN
    else if (rcl_go) b_d = {b_q[DW-2:0], carry_in};
`endif
  end

  // Flags follow the ALU only when enabled; a rotate owns the carry bit
  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (eu) begin
      zero_d  = is_zero(alu_y);
      carry_d = alu_c;
    end
    if (rcl_go) carry_d = b_q[DW-1];
  end

  // State registers with synchronous active-low reset overriding all strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_sap_alu_ab_datapath.sv
// Bench for sap_alu_ab_datapath: directed vector table with hand-derived
// expectations, then randomized cycles against an arithmetic reference model.
module tb_sap_alu_ab_datapath;
  import sap_pkg::*;

`ifdef SAP_RCL_EN
  localparam bit RCL = 1'b1;
`else
  localparam bit RCL = 1'b0;
`endif

  // Strobe bit masks for the vector table
  localparam logic [7:0] S_LA_RAM = 8'b0000_0001;
  localparam logic [7:0] S_LA_B   = 8'b0000_0010;
  localparam logic [7:0] S_LA_ALU = 8'b0000_0100;
  localparam logic [7:0] S_LB_TMP = 8'b0000_1000;
  localparam logic [7:0] S_LB_ALU = 8'b0001_0000;
  localparam logic [7:0] S_LB_POP = 8'b0010_0000;
  localparam logic [7:0] S_EU     = 8'b0100_0000;
  localparam logic [7:0] S_ERCL   = 8'b1000_0000;

  localparam int W = 2*DW + 2;

  typedef struct {
    logic          rst_n;
    logic [3:0]    op;
    logic [DW-1:0] ram;
    logic [DW-1:0] tmp;
    logic [DW-1:0] pop;
    logic          cin;
    logic [7:0]    s;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          ez;
    logic          ec;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [3:0]    opcode;
  logic [DW-1:0] ram_din, tmp_din, pop_din;
  logic          carry_in;
  logic          la_ram, la_b, la_alu, lb_tmp, lb_alu, lb_pop, eu, ercl;
  logic [DW-1:0] a_q, b_q, alu_y;
  logic          zero, carry;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  // Reference model state (plain integers)
  int m_a, m_b, m_z, m_c;

  sap_alu_ab_datapath dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .ram_din(ram_din), .tmp_din(tmp_din), .pop_din(pop_din),
    .carry_in(carry_in), .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
    .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lb_pop(lb_pop), .eu(eu), .ercl(ercl),
    .a_q(a_q), .b_q(b_q), .alu_y(alu_y), .zero(zero), .carry(carry)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] op, int ram, int tmp, int pop,
                              logic cin, logic [7:0] s, int ea, int eb, int ez, int ec);
    vec_t v;
    v.rst_n = r; v.op = op; v.ram = DW'(ram); v.tmp = DW'(tmp); v.pop = DW'(pop);
    v.cin = cin; v.s = s; v.ea = DW'(ea); v.eb = DW'(eb); v.ez = ez[0]; v.ec = ec[0];
    return v;
  endfunction

  // ALU behaviour from the opcode rules, using integer arithmetic
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int y, output int c);
    int m;
    m = 1 << DW;
    y = a; c = 0;
    case (op)
      1: begin y = (a + b) % m; c = (a + b >= m) ? 1 : 0; end
      2: begin y = (a - b + m) % m; c = (a < b) ? 1 : 0; end
      4: begin y = a & b; c = 0; end
      5: begin y = a / 2; c = a % 2; end
      6: begin y = (a * 2) % m; c = (a >= m/2) ? 1 : 0; end
      default: begin y = a; c = 0; end
    endcase
  endfunction

  // Advance the model by one clock edge
  task automatic model_step(input vec_t v);
    int y, c, na, nb, nz, nc;
    if (!v.rst_n) begin
      m_a = 0; m_b = 0; m_z = 0; m_c = 0;
      return;
    end
    ref_alu(int'(v.op), m_a, m_b, y, c);
    na = m_a; nb = m_b; nz = m_z; nc = m_c;
    if (v.s & S_LA_ALU)      na = y;
    else if (v.s & S_LA_B)   na = m_b;
    else if (v.s & S_LA_RAM) na = int'(v.ram);
    if (v.s & S_EU) begin nz = (y == 0) ? 1 : 0; nc = c; end
    if (v.s & S_LB_ALU)      nb = y;
    else if (v.s & S_LB_TMP) nb = int'(v.tmp);
    else if (v.s & S_LB_POP) nb = int'(v.pop);
    else if (RCL && (v.s & S_ERCL)) begin
      nb = (m_b * 2) % (1 << DW) + int'(v.cin);
      nc = (m_b >= (1 << (DW-1))) ? 1 : 0;
    end
    m_a = na; m_b = nb; m_z = nz; m_c = nc;
  endtask

  // Driver: apply one vector's inputs
  task automatic drive(input vec_t v);
    reset = v.rst_n; opcode = v.op;
    ram_din = v.ram; tmp_din = v.tmp; pop_din = v.pop; carry_in = v.cin;
    la_ram = v.s[0]; la_b = v.s[1]; la_alu = v.s[2]; lb_tmp = v.s[3];
    lb_alu = v.s[4]; lb_pop = v.s[5]; eu = v.s[6]; ercl = v.s[7];
  endtask

  task automatic check1(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Scoreboard: pop the expected state and compare each field
  task automatic score(input int step);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check1("sb_empty", step, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check1("a_q",   step, int'(a_q),   int'(e[W-1 -: DW]));
    check1("b_q",   step, int'(b_q),   int'(e[DW+1 -: DW]));
    check1("zero",  step, int'(zero),  int'(e[1]));
    check1("carry", step, int'(carry), int'(e[0]));
  endtask

  initial begin
    vec_t v;
    int y, c;
    drive(mk(1'b0, 4'h0, 0, 0, 0, 1'b0, 8'h00, 0, 0, 0, 0));
    m_a = 0; m_b = 0; m_z = 0; m_c = 0;

    // Directed sequence; state carries from one row to the next
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, S_LA_RAM | S_EU, 0, 0, 0, 0));    // reset wins
    vecs.push_back(mk(1, 4'h0, 4'hB, 0, 0, 0, S_LA_RAM, 4'hB, 0, 0, 0));        // MOV A,[]
    vecs.push_back(mk(1, 4'h3, 0, 4'hB, 0, 0, S_LA_B | S_LB_TMP, 0, 4'hB, 0, 0)); // XCHG
    vecs.push_back(mk(1, 4'h0, 4'hE, 0, 0, 0, S_LA_RAM, 4'hE, 4'hB, 0, 0));
    vecs.push_back(mk(1, 4'h1, 0, 0, 0, 0, S_EU | S_LA_ALU, 4'h9, 4'hB, 0, 1)); // ADD
    vecs.push_back(mk(1, 4'h5, 0, 0, 0, 0, S_EU | S_LA_ALU, 4'h4, 4'hB, 0, 1)); // SHR
    vecs.push_back(mk(1, 4'h0, 4'h1, 0, 0, 0, S_LA_RAM, 4'h1, 4'hB, 0, 1));
    vecs.push_back(mk(1, 4'h5, 0, 0, 0, 0, S_EU | S_LA_ALU, 4'h0, 4'hB, 1, 1)); // SHR to 0
    vecs.push_back(mk(1, 4'h0, 4'h3, 0, 0, 0, S_LA_RAM, 4'h3, 4'hB, 1, 1));
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h5, 0, S_LB_POP, 4'h3, 4'h5, 1, 1));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 0, S_EU | S_LA_ALU, 4'hE, 4'h5, 0, 1)); // SUB wrap
    vecs.push_back(mk(1, 4'h0, 4'h7, 0, 0, 0, S_LA_RAM, 4'h7, 4'h5, 0, 1));
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h7, 0, S_LB_POP, 4'h7, 4'h7, 0, 1));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 0, S_EU | S_LA_ALU, 4'h0, 4'h7, 1, 0)); // SUB equal
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h9, 0, S_LB_POP, 4'h0, 4'h9, 1, 0));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, S_ERCL, 4'h0, RCL ? 4'h2 : 4'h9, 1, RCL ? 1 : 0)); // RCL
    vecs.push_back(mk(1, 4'h0, 4'h6, 0, 0, 0, S_LA_RAM, 4'h6, RCL ? 4'h2 : 4'h9, 1, RCL ? 1 : 0));
    vecs.push_back(mk(1, 4'h6, 0, 4'h1, 4'h2, 0, S_LB_ALU | S_LB_TMP | S_LB_POP,
                      4'h6, 4'hC, 1, RCL ? 1 : 0));                            // B priority
    vecs.push_back(mk(1, 4'h4, 4'h1, 0, 0, 0, S_LA_ALU | S_LA_B | S_LA_RAM | S_EU,
                      4'h4, 4'hC, 0, 0));                                       // A priority, AND
    vecs.push_back(mk(1, 4'h1, 0, 0, 0, 0, S_EU, 4'h4, 4'hC, 1, 1));           // flags only
    vecs.push_back(mk(0, 4'h1, 4'h5, 4'h5, 4'h5, 0, S_LA_RAM | S_LB_TMP | S_EU, 0, 0, 0, 0)); // reset mid

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back({vecs[i].ea, vecs[i].eb, vecs[i].ez, vecs[i].ec});
      @(posedge clk);
      #1;
      score(i);
    end

    // Randomized cycles against the reference model
    m_a = 0; m_b = 0; m_z = 0; m_c = 0;
    for (int i = 0; i < 400; i++) begin
      v.rst_n = ($urandom_range(0, 31) != 0);
      v.op    = 4'($urandom_range(0, 15));
      v.ram   = DW'($urandom);
      v.tmp   = DW'($urandom);
      v.pop   = DW'($urandom);
      v.cin   = 1'($urandom);
      v.s     = 8'($urandom) & 8'($urandom);
      v.ea = '0; v.eb = '0; v.ez = 1'b0; v.ec = 1'b0;
      drive(v);
      model_step(v);
      exp_q.push_back({DW'(m_a), DW'(m_b), 1'(m_z), 1'(m_c)});
      @(posedge clk);
      #1;
      score(1000 + i);
      ref_alu(int'(opcode), m_a, m_b, y, c);
      check1("alu_y", 1000 + i, int'(alu_y), y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
